// File: rtl/pipeline_fifo_buffer_pkg.sv
// Shared definitions for the pipeline FIFO buffer.
//   CLOG2(x)    : project-wide ceiling-log2 macro used to size pointers and counts.
//   cnt_op_e    : occupancy counter operation for one cycle (hold, increment, decrement).
//   cnt_op()    : maps the push and stored-pop strobes to a counter operation.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package pipeline_fifo_buffer_pkg;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // Simultaneous push and pop leave the occupancy unchanged.
    function automatic cnt_op_e cnt_op(input logic push, input logic pop);
        cnt_op_e op;
        op = CNT_HOLD;
        if (push && !pop) begin
            op = CNT_INC;
        end else if (!push && pop) begin
            op = CNT_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/pipeline_fifo_buffer.sv
// Pipeline FIFO buffer with optional empty-buffer fall-through.
//   clock_i      : sole clock, rising edge
//   reset_i      : synchronous active-high reset (overrides clear_i)
//   clear_i      : synchronous flush of pointers, count and error flags
//   valid_i      : producer presents data_i
//   data_i       : write data
//   ready_o      : buffer can accept a write (== !full_o)
//   read_i       : consumer pops the head this cycle
//   valid_o      : data_o holds valid head data
//   data_o       : head data (bypassed data_i when empty and BYPASS=1)
//   count_o      : number of stored entries
//   full_o       : count_o == N_ENTRIES
//   empty_o      : count_o == 0
//   overflow_o   : sticky, write attempted while full
//   underflow_o  : sticky, read attempted with no valid head
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module pipeline_fifo_buffer
    import pipeline_fifo_buffer_pkg::*;
#(
    parameter int unsigned N_ENTRIES = 4,
    parameter int unsigned BW_DATA   = 32,
    parameter bit          BYPASS    = 1'b1
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           clear_i,
    input  logic                           valid_i,
    input  logic [BW_DATA-1:0]             data_i,
    output logic                           ready_o,
    input  logic                           read_i,
    output logic                           valid_o,
    output logic [BW_DATA-1:0]             data_o,
    output logic [`CLOG2(N_ENTRIES):0]     count_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic                           overflow_o,
    output logic                           underflow_o
);

    localparam int unsigned PTR_W = `CLOG2(N_ENTRIES);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [BW_DATA-1:0] mem_q [N_ENTRIES];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               ovf_q,    ovf_d;
    logic               unf_q,    unf_d;

    logic empty, full, bypass_empty;
    logic push, pop_store;

    always_comb begin
        empty        = (count_q == '0);
        full         = (count_q == CNT_W'(N_ENTRIES));
        bypass_empty = BYPASS && empty;

        // Empty buffer: head is the live input when bypassing, never during a clear.
        valid_o = empty ? (bypass_empty && valid_i && !clear_i) : 1'b1;
        data_o  = bypass_empty ? data_i : mem_q[rd_ptr_q];

        // A bypassed word consumed in the same cycle never touches storage.
        push      = valid_i && !full && !(bypass_empty && read_i);
        pop_store = read_i && !empty;

        wr_ptr_d = push      ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_store ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        unique case (cnt_op(push, pop_store))
            CNT_INC: count_d = count_q + CNT_W'(1);
            CNT_DEC: count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        ovf_d = ovf_q || (valid_i && full);
        unf_d = unf_q || (read_i && !valid_o);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is not reset; stale words are unreachable once count_q is zero.
    always_ff @(posedge clock_i) begin
        if (push && !clear_i && !reset_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign ready_o     = !full;
    assign full_o      = full;
    assign empty_o     = empty;
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: tb/tb_pipeline_fifo_buffer.sv
module tb_pipeline_fifo_buffer;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;

    // BYPASS=1 instance
    logic         c1, v1, r1;
    logic [W-1:0] d1, q1;
    logic         rdy1, vo1, full1, emp1, ovf1, unf1;
    logic [2:0]   cnt1;

    // BYPASS=0 instance
    logic         c0, v0, r0;
    logic [W-1:0] d0, q0;
    logic         rdy0, vo0, full0, emp0, ovf0, unf0;
    logic [2:0]   cnt0;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_fifo_buffer #(.N_ENTRIES(N), .BW_DATA(W), .BYPASS(1'b1)) dut1 (
        .clock_i(clk), .reset_i(rst), .clear_i(c1), .valid_i(v1), .data_i(d1),
        .ready_o(rdy1), .read_i(r1), .valid_o(vo1), .data_o(q1), .count_o(cnt1),
        .full_o(full1), .empty_o(emp1), .overflow_o(ovf1), .underflow_o(unf1)
    );

    pipeline_fifo_buffer #(.N_ENTRIES(N), .BW_DATA(W), .BYPASS(1'b0)) dut0 (
        .clock_i(clk), .reset_i(rst), .clear_i(c0), .valid_i(v0), .data_i(d0),
        .ready_o(rdy0), .read_i(r0), .valid_o(vo0), .data_o(q0), .count_o(cnt0),
        .full_o(full0), .empty_o(emp0), .overflow_o(ovf0), .underflow_o(unf0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Commit current inputs on the next rising edge, then settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the BYPASS=1 instance and let combinational outputs settle.
    task automatic drv1(input logic v, input logic [W-1:0] d, input logic r, input logic c);
        v1 = v; d1 = d; r1 = r; c1 = c;
        #1;
    endtask

    task automatic drv0(input logic v, input logic [W-1:0] d, input logic r, input logic c);
        v0 = v; d0 = d; r0 = r; c0 = c;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        v1 = 1'b0; d1 = '0; r1 = 1'b0; c1 = 1'b0;
        v0 = 1'b0; d0 = '0; r0 = 1'b0; c0 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_count", 32'(cnt1), 32'd0);
        chk("rst_empty", 32'(emp1), 32'd1);
        chk("rst_full",  32'(full1), 32'd0);
        chk("rst_ready", 32'(rdy1), 32'd1);
        chk("rst_ovf",   32'(ovf1), 32'd0);
        chk("rst_unf",   32'(unf1), 32'd0);
        chk("rst_valid_idle", 32'(vo1), 32'd0);
        drv1(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("rst_valid_bypass", 32'(vo1), 32'd1);
        chk("rst_valid_b0", 32'(vo0), 32'd0);

        // Fall-through with simultaneous read
        drv1(1'b1, 8'hA5, 1'b1, 1'b0);
        chk("ft_valid", 32'(vo1), 32'd1);
        chk("ft_data",  32'(q1), 32'hA5);
        tick();
        drv1(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ft_count", 32'(cnt1), 32'd0);
        chk("ft_unf",   32'(unf1), 32'd0);

        // Fill and drain
        for (int i = 1; i <= 4; i++) begin
            drv1(1'b1, W'(i), 1'b0, 1'b0);
            tick();
        end
        drv1(1'b0, 8'h00, 1'b0, 1'b0);
        chk("fill_full",  32'(full1), 32'd1);
        chk("fill_ready", 32'(rdy1), 32'd0);
        chk("fill_count", 32'(cnt1), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            drv1(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_valid", 32'(vo1), 32'd1);
            chk("drain_data",  32'(q1), 32'(i));
            tick();
        end
        drv1(1'b0, 8'h00, 1'b0, 1'b0);
        chk("drain_empty", 32'(emp1), 32'd1);
        chk("drain_count", 32'(cnt1), 32'd0);

        // Overflow: write to a full buffer is dropped
        for (int i = 0; i < 4; i++) begin
            drv1(1'b1, W'(8'h11 + i), 1'b0, 1'b0);
            tick();
        end
        drv1(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("ovf_ready", 32'(rdy1), 32'd0);
        tick();
        drv1(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf_flag",  32'(ovf1), 32'd1);
        chk("ovf_count", 32'(cnt1), 32'd4);
        for (int i = 0; i < 4; i++) begin
            drv1(1'b0, 8'h00, 1'b1, 1'b0);
            chk("ovf_intact", 32'(q1), 32'(8'h11 + i));
            tick();
        end
        drv1(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf_hold", 32'(ovf1), 32'd1);

        // Clear with 3 entries stored and a concurrent write
        for (int i = 0; i < 3; i++) begin
            drv1(1'b1, W'(8'h21 + i), 1'b0, 1'b0);
            tick();
        end
        chk("clr_pre_count", 32'(cnt1), 32'd3);
        drv1(1'b1, 8'h77, 1'b0, 1'b1);
        tick();
        drv1(1'b0, 8'h00, 1'b0, 1'b0);
        chk("clr_count", 32'(cnt1), 32'd0);
        chk("clr_empty", 32'(emp1), 32'd1);
        chk("clr_ovf",   32'(ovf1), 32'd0);
        chk("clr_valid", 32'(vo1), 32'd0);

        // Clear while empty suppresses the bypass transfer
        drv1(1'b1, 8'h33, 1'b1, 1'b1);
        chk("clr_nobypass", 32'(vo1), 32'd0);
        tick();
        drv1(1'b0, 8'h00, 1'b0, 1'b0);
        chk("clr_nb_count", 32'(cnt1), 32'd0);
        chk("clr_nb_unf",   32'(unf1), 32'd0);

        // Wrap: 6 pushes, pop every cycle from cycle 2
        drv1(1'b1, 8'h40, 1'b0, 1'b0); tick();
        chk("wrap_c0", 32'(cnt1), 32'd1);
        drv1(1'b1, 8'h41, 1'b0, 1'b0); tick();
        chk("wrap_c1", 32'(cnt1), 32'd2);
        for (int i = 0; i < 4; i++) begin
            drv1(1'b1, W'(8'h42 + i), 1'b1, 1'b0);
            chk("wrap_data", 32'(q1), 32'(8'h40 + i));
            tick();
            chk("wrap_count", 32'(cnt1), 32'd2);
        end
        for (int i = 4; i < 6; i++) begin
            drv1(1'b0, 8'h00, 1'b1, 1'b0);
            chk("wrap_tail", 32'(q1), 32'(8'h40 + i));
            tick();
        end
        drv1(1'b0, 8'h00, 1'b0, 1'b0);
        chk("wrap_empty", 32'(emp1), 32'd1);

        // Reset overrides clear; stored entries and flags discarded
        drv1(1'b1, 8'h51, 1'b0, 1'b0); tick();
        drv1(1'b1, 8'h52, 1'b0, 1'b0); tick();
        drv1(1'b1, 8'h53, 1'b1, 1'b0); tick();
        drv1(1'b0, 8'h00, 1'b1, 1'b0); tick();
        drv1(1'b0, 8'h00, 1'b1, 1'b0); tick();
        drv1(1'b0, 8'h00, 1'b1, 1'b0); tick();
        drv1(1'b0, 8'h00, 1'b0, 1'b0);
        chk("pre_rst_unf", 32'(unf1), 32'd1);
        drv1(1'b1, 8'h54, 1'b0, 1'b0); tick();
        drv1(1'b1, 8'h55, 1'b0, 1'b0); tick();
        chk("pre_rst_count", 32'(cnt1), 32'd2);
        rst = 1'b1;
        drv1(1'b1, 8'h56, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        drv1(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rc_count", 32'(cnt1), 32'd0);
        chk("rc_empty", 32'(emp1), 32'd1);
        chk("rc_valid", 32'(vo1), 32'd0);
        chk("rc_unf",   32'(unf1), 32'd0);
        chk("rc_ready", 32'(rdy1), 32'd1);

        // BYPASS=0 latency
        drv0(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("b0_valid_same", 32'(vo0), 32'd0);
        tick();
        drv0(1'b0, 8'h00, 1'b0, 1'b0);
        chk("b0_valid_next", 32'(vo0), 32'd1);
        chk("b0_data_next",  32'(q0), 32'h5A);
        chk("b0_count",      32'(cnt0), 32'd1);
        drv0(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        drv0(1'b0, 8'h00, 1'b0, 1'b0);
        chk("b0_empty", 32'(emp0), 32'd1);
        chk("b0_unf_clean", 32'(unf0), 32'd0);

        // BYPASS=0 underflow holds until clear
        drv0(1'b1, 8'h66, 1'b1, 1'b0);
        chk("b0_unf_valid", 32'(vo0), 32'd0);
        tick();
        drv0(1'b0, 8'h00, 1'b0, 1'b0);
        chk("b0_unf_set", 32'(unf0), 32'd1);
        chk("b0_unf_stored", 32'(cnt0), 32'd1);
        tick();
        chk("b0_unf_hold", 32'(unf0), 32'd1);
        drv0(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        drv0(1'b0, 8'h00, 1'b0, 1'b0);
        chk("b0_unf_clr", 32'(unf0), 32'd0);
        chk("b0_clr_count", 32'(cnt0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
